sc_fifo: RTL and testbench

//  Single-clock synchronous FIFO: a drop-in replacement for the vendor FIFO primitive used as the

---
 rtl/sc_fifo_pkg.sv | 20 ++
 rtl/sc_fifo_ram.sv | 25 ++
 rtl/sc_fifo.sv | 146 ++++++++++++++
 tb/tb_sc_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sc_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
package sc_fifo_pkg;

  localparam int unsigned ECC_W    = 2;
  localparam logic [1:0]  ECC_NONE = 2'b00;

  // Per-cycle operation, indexed as {do_wr, do_rd}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  // The count needs one bit more than usedw so that a full FIFO is distinguishable.
  function automatic int unsigned cnt_width(input int unsigned widthu);
    return widthu + 1;
  endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sc_fifo_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sc_fifo.sv
// Single-clock FIFO, drop-in for the vendor FIFO primitive (show-ahead or registered q).
module sc_fifo
  import sc_fifo_pkg::*;
#(
  parameter int unsigned LPM_WIDTH               = 8,
  parameter int unsigned LPM_NUMWORDS            = 16,
  parameter int unsigned LPM_WIDTHU              = 4,
  parameter string       LPM_SHOWAHEAD           = "ON",
  parameter string       OVERFLOW_CHECKING       = "ON",
  parameter string       UNDERFLOW_CHECKING      = "ON",
  parameter string       ALLOW_RWCYCLE_WHEN_FULL = "ON",
  parameter int unsigned ALMOST_FULL_VALUE       = LPM_NUMWORDS - 1,
  parameter int unsigned ALMOST_EMPTY_VALUE      = 1,
  parameter bit          REPORT_MISUSE           = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  sclr,
  input  logic [LPM_WIDTH-1:0]  data,
  input  logic                  wrreq,
  output logic                  full,
  output logic [LPM_WIDTH-1:0]  q,
  input  logic                  rdreq,
  output logic                  empty,
  output logic [LPM_WIDTHU-1:0] usedw,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ECC_W-1:0]      eccstatus
);

  localparam bit SHOWAHEAD = (LPM_SHOWAHEAD == "ON");
  localparam bit OVF_CHK   = (OVERFLOW_CHECKING == "ON");
  localparam bit UNF_CHK   = (UNDERFLOW_CHECKING == "ON");
  localparam bit RW_FULL   = (ALLOW_RWCYCLE_WHEN_FULL == "ON");

  localparam int unsigned     CW       = cnt_width(LPM_WIDTHU);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(LPM_NUMWORDS);
  localparam logic [CW-1:0]   AF_C     = CW'(ALMOST_FULL_VALUE);
  localparam logic [CW-1:0]   AE_C     = CW'(ALMOST_EMPTY_VALUE);
  localparam logic [LPM_WIDTHU-1:0] LAST_PTR = LPM_WIDTHU'(LPM_NUMWORDS - 1);

  logic [LPM_WIDTHU-1:0] wr_ptr_q, wr_ptr_d;
  logic [LPM_WIDTHU-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_wr, do_rd;
  logic [LPM_WIDTH-1:0]  ram_rdata;
  fifo_op_e              op;

  // Depth need not be a power of two, so wrap explicitly rather than by overflow.
  function automatic logic [LPM_WIDTHU-1:0] ptr_inc(input logic [LPM_WIDTHU-1:0] p);
    return (p == LAST_PTR) ? '0 : p + LPM_WIDTHU'(1);
  endfunction

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign usedw        = count_q[LPM_WIDTHU-1:0];
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q < AE_C);
  assign eccstatus    = ECC_NONE;

  always_comb begin
    do_wr = wrreq;
    if (OVF_CHK) begin
      do_wr = wrreq & (~full | (RW_FULL & rdreq));
    end
    do_rd = rdreq;
    if (UNF_CHK) begin
      do_rd = rdreq & ~empty;
    end
    op       = fifo_op_e'({do_wr, do_rd});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_rd) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case (op)
      OP_WR:   count_d = count_q + CW'(1);
      OP_RD:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sc_fifo_ram #(
    .WIDTH (LPM_WIDTH),
    .DEPTH (LPM_NUMWORDS),
    .AW    (LPM_WIDTHU)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (do_wr & ~sclr),
    .waddr_i (wr_ptr_q),
    .wdata_i (data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  if (SHOWAHEAD) begin : g_showahead
    assign q = empty ? '0 : ram_rdata;
  end else begin : g_registered
    logic [LPM_WIDTH-1:0] q_q;
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        q_q <= '0;
      end else if (sclr) begin
        q_q <= '0;
      end else if (do_rd) begin
        q_q <= ram_rdata;
      end
    end
    assign q = q_q;
  end

  if (REPORT_MISUSE) begin : g_misuse
    always_ff @(posedge CLK) begin
      if (RST_N && !sclr) begin
        if (OVF_CHK && wrreq && full) begin
          $error("sc_fifo: wrreq while full");
        end
        if (UNF_CHK && rdreq && empty) begin
          $error("sc_fifo: rdreq while empty");
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_fifo.sv
// Scoreboard bench for sc_fifo: depth 4, show-ahead, all checks on.
module tb_sc_fifo;

  localparam int unsigned DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       sclr = 1'b0;
  logic [7:0] data = '0;
  logic       wrreq = 1'b0;
  logic       rdreq = 1'b0;
  logic       full, empty, almost_full, almost_empty;
  logic [7:0] q;
  logic [1:0] usedw;
  logic [1:0] eccstatus;

  sc_fifo #(
    .LPM_WIDTH         (8),
    .LPM_NUMWORDS      (4),
    .LPM_WIDTHU        (2),
    .ALMOST_FULL_VALUE (3),
    .ALMOST_EMPTY_VALUE(1),
    .REPORT_MISUSE     (1'b0)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .sclr        (sclr),
    .data        (data),
    .wrreq       (wrreq),
    .full        (full),
    .q           (q),
    .rdreq       (rdreq),
    .empty       (empty),
    .usedw       (usedw),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .eccstatus   (eccstatus)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  sb [$];
  bit          mon_en = 1'b0;
  bit          wr_ok;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: flags follow the model occupancy; each presented head word is checked and retired on rdreq.
  always @(negedge CLK) begin
    int unsigned n;
    if (mon_en) begin
      n = sb.size();
      chk("empty", empty, n == 0);
      chk("full", full, n == DEPTH);
      chk("usedw", usedw, n % DEPTH);
      chk("almost_full", almost_full, n >= 3);
      chk("almost_empty", almost_empty, n < 1);
      chk("eccstatus", eccstatus, 0);
      if (empty) begin
        chk("q_when_empty", q, 0);
      end else if (n == 0) begin
        chk("q_unexpected_word", 1, 0);
      end else begin
        chk("q_head", q, sb[0]);
        if (rdreq) void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input bit w, input bit r, input logic [7:0] d, input bit c);
    wrreq = w;
    rdreq = r;
    data  = d;
    sclr  = c;
    wr_ok = w && ((sb.size() < DEPTH) || r);
  endtask

  task automatic step();
    @(posedge CLK);
    if (sclr) sb.delete();
    else if (wr_ok) sb.push_back(data);
    #1;
  endtask

  task automatic cycle(input bit w, input bit r, input logic [7:0] d, input bit c);
    drive(w, r, d, c);
    step();
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic mid_reset();
    wrreq = 1'b0;
    rdreq = 1'b0;
    sclr  = 1'b0;
    wr_ok = 1'b0;
    RST_N = 1'b0;
    sb.delete();
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_usedw", usedw, 0);
    chk("rst_q", q, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    #2 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("init_empty", empty, 1);
    chk("init_full", full, 0);
    chk("init_usedw", usedw, 0);
    chk("init_almost_empty", almost_empty, 1);
    chk("init_almost_full", almost_full, 0);
    chk("init_q", q, 0);
    RST_N  = 1'b1;
    mon_en = 1'b1;

    // Write on empty: no fall-through.
    drive(1'b1, 1'b0, 8'hA1, 1'b0);
    #2 chk("a1_same_cycle_empty", empty, 1);
    step();
    chk("a1_empty", empty, 0);
    chk("a1_q", q, 8'hA1);
    chk("a1_usedw", usedw, 1);
    drain();

    // Fill, overflow attempt, then in-order drain.
    for (int unsigned i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0);
    chk("fill_full", full, 1);
    chk("fill_usedw", usedw, 0);
    chk("fill_almost_full", almost_full, 1);
    chk("fill_q", q, 8'h01);
    for (int unsigned i = 1; i <= 4; i++) begin
      chk("order_q", q, i);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end
    chk("drained_empty", empty, 1);

    // Read+write while full.
    for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h11 + 8'(i), 1'b0);
    cycle(1'b1, 1'b1, 8'h55, 1'b0);
    chk("rw_full_full", full, 1);
    chk("rw_full_usedw", usedw, 0);
    chk("rw_full_q", q, 8'h02 + 8'h10);
    for (int unsigned i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rw_full_last", q, 8'h55);
    drain();

    // Read+write while empty: only the write lands.
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    chk("rw_empty_usedw", usedw, 1);
    chk("rw_empty_q", q, 8'h77);
    drain();

    // Pointer wrap with interleaved pairs.
    for (int unsigned i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      cycle(1'b1, 1'b0, d, 1'b0);
      chk("wrap_q", q, d);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end

    // Synchronous clear with two words held.
    cycle(1'b1, 1'b0, 8'hC1, 1'b0);
    cycle(1'b1, 1'b0, 8'hC2, 1'b0);
    cycle(1'b1, 1'b1, 8'hC3, 1'b1);
    chk("sclr_empty", empty, 1);
    chk("sclr_usedw", usedw, 0);

    // Asynchronous reset mid-traffic.
    for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'hD0 + 8'(i), 1'b0);
    mid_reset();

    // Random traffic.
    for (int unsigned i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 8'($urandom),
            $urandom_range(0, 99) == 0);
      if (i == 300) mid_reset();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
